ht_cmd_arbiter: RTL and testbench

//  Shares the hash table command port between N_REQ requesters with round-robin arbitration.

---
 rtl/ht_cmd_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ht_cmd_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_cmd_arbiter.sv
// Round-robin arbiter for the hash table command port. Tags each issued command so its
// result returns to the right requester, and serialises OP_INIT behind a drained pipe.

package ht_pkg;
   typedef enum logic [1:0] {
      OP_SEARCH = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2,
      OP_INIT   = 2'd3
   } ht_op_e;

   typedef struct packed {
      ht_op_e      op;
      logic [15:0] key;
      logic [15:0] value;
   } ht_command_t;

   typedef struct packed {
      ht_command_t cmd;
      logic        hit;
      logic [15:0] value;
   } ht_result_t;
endpackage

module ht_cmd_arbiter
   import ht_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int TAG_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  ht_command_t [N_REQ-1:0]       req_cmd_i,
   input  logic [N_REQ-1:0]              req_valid_i,
   output logic [N_REQ-1:0]              req_ready_o,
   output ht_command_t                   ht_cmd_o,
   output logic                          ht_cmd_valid_o,
   input  logic                          ht_cmd_ready_i,
   input  ht_result_t                    ht_result_i,
   input  logic                          ht_result_valid_i,
   output ht_result_t                    res_o,
   output logic [N_REQ-1:0]              res_valid_o,
   output logic [$clog2(TAG_DEPTH):0]    in_flight_o,
   output logic                          err_o
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int AW = $clog2(TAG_DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [IW-1:0] id;
      logic          is_init;
   } tag_t;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      DRAIN     = 2'd1,
      INIT_WAIT = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [IW-1:0]     lock_q, lock_d;
   ht_command_t       cmd_q;
   logic              cmd_vld_q;
   logic [CW-1:0]     wr_ptr_q, rd_ptr_q;
   tag_t              tag_mem [TAG_DEPTH];
   ht_result_t        res_q;
   logic [N_REQ-1:0]  res_vld_q, res_vld_d;
   logic              err_q;

   logic [CW-1:0]     count;
   logic              fifo_empty, pop, full_blk, slot_free, pipe_busy;
   tag_t              head;
   logic [N_REQ-1:0]  hi_req, pick, rdy_d;
   logic [IW-1:0]     arb_id, sel;
   logic              arb_vld, grant, sel_init;

   assign count      = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (count == '0);
   assign head       = tag_mem[rd_ptr_q[AW-1:0]];
   assign pop        = ht_result_valid_i & ~fifo_empty;
   // A same-cycle pop frees the slot the new push needs, so a full FIFO can still accept.
   assign full_blk   = (count == CW'(TAG_DEPTH)) & ~pop;
   assign slot_free  = ~cmd_vld_q | ht_cmd_ready_i;
   assign pipe_busy  = ~fifo_empty | cmd_vld_q;

   // Requesters above the last grant win first; otherwise wrap to the lowest index.
   always_comb begin
      hi_req = '0;
      for (int i = 0; i < N_REQ; i++)
         hi_req[i] = req_valid_i[i] & (IW'(i) > rr_q);
      pick    = (|hi_req) ? hi_req : req_valid_i;
      arb_vld = |req_valid_i;
      arb_id  = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (pick[i]) arb_id = IW'(i);
   end

   always_comb begin
      state_d  = state_q;
      lock_d   = lock_q;
      grant    = 1'b0;
      sel      = arb_id;
      case (state_q)
         RUN: begin
            if (arb_vld) begin
               if (req_cmd_i[arb_id].op == OP_INIT) begin
                  if (pipe_busy) begin
                     state_d = DRAIN;
                     lock_d  = arb_id;
                  end else if (!full_blk) begin
                     grant   = 1'b1;
                     state_d = INIT_WAIT;
                  end
               end else if (slot_free && !full_blk) begin
                  grant = 1'b1;
               end
            end
         end
         DRAIN: begin
            sel = lock_q;
            if (req_valid_i[lock_q] && !pipe_busy && !pop) begin
               grant   = 1'b1;
               state_d = INIT_WAIT;
            end
         end
         INIT_WAIT: begin
            if (pop && head.is_init) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign sel_init = (req_cmd_i[sel].op == OP_INIT);
   assign rr_d     = grant ? sel : rr_q;

   always_comb begin
      rdy_d = '0;
      if (grant) rdy_d[sel] = 1'b1;
      res_vld_d = '0;
      if (pop) res_vld_d[head.id] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= RUN;
         rr_q      <= IW'(N_REQ - 1);
         lock_q    <= '0;
         cmd_q     <= '0;
         cmd_vld_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         res_q     <= '0;
         res_vld_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         lock_q    <= lock_d;
         if (grant) begin
            cmd_q     <= req_cmd_i[sel];
            cmd_vld_q <= 1'b1;
         end else if (ht_cmd_ready_i) begin
            cmd_vld_q <= 1'b0;
         end
         if (grant) wr_ptr_q <= wr_ptr_q + CW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + CW'(1);
         if (ht_result_valid_i) res_q <= ht_result_i;
         res_vld_q <= res_vld_d;
         if (ht_result_valid_i && fifo_empty) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (grant) tag_mem[wr_ptr_q[AW-1:0]] <= '{id: sel, is_init: sel_init};
   end

   // Ready is gated by reset so every output reads 0 while reset is held.
   assign req_ready_o    = rdy_d & {N_REQ{rst_n_i}};
   assign ht_cmd_o       = cmd_q;
   assign ht_cmd_valid_o = cmd_vld_q;
   assign res_o          = res_q;
   assign res_valid_o    = res_vld_q;
   assign in_flight_o    = count;
   assign err_o          = err_q;

endmodule

// File: tb/tb_ht_cmd_arbiter.sv
// Directed bench for ht_cmd_arbiter: a small hash table model returns results in order,
// and a scoreboard of expected {owner, key} pairs is checked as results come back.

module tb_ht_cmd_arbiter;
   import ht_pkg::*;

   localparam int N   = 4;
   localparam int TD  = 16;
   localparam int LAT = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   ht_command_t [N-1:0] req_cmd;
   logic [N-1:0]        req_valid, req_ready;
   ht_command_t         ht_cmd;
   logic                ht_cmd_valid, ht_cmd_ready;
   ht_result_t          ht_result, res;
   logic                ht_result_valid;
   logic [N-1:0]        res_valid;
   logic [4:0]          in_flight;
   logic                err;

   always #5 clk = ~clk;

   ht_cmd_arbiter #(.N_REQ(N), .TAG_DEPTH(TD)) dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n),
      .req_cmd_i         (req_cmd),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready),
      .ht_cmd_o          (ht_cmd),
      .ht_cmd_valid_o    (ht_cmd_valid),
      .ht_cmd_ready_i    (ht_cmd_ready),
      .ht_result_i       (ht_result),
      .ht_result_valid_i (ht_result_valid),
      .res_o             (res),
      .res_valid_o       (res_valid),
      .in_flight_o       (in_flight),
      .err_o             (err)
   );

   typedef struct {
      int          id;
      logic [15:0] key;
   } exp_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc    = 0;
   int          n_res  = 0;
   bit          ht_auto  = 1'b0;
   bit          rule_chk = 1'b0;
   ht_command_t hq_cmd[$];
   int          hq_due[$];
   exp_t        exp_q[$];
   logic [N-1:0]        pv_v = '0, pv_r = '0;
   ht_command_t [N-1:0] pv_c;

   function automatic ht_command_t mk(input ht_op_e op, input logic [15:0] key);
      ht_command_t c;
      c.op    = op;
      c.key   = key;
      c.value = ~key;
      return c;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int id, input logic [15:0] key);
      exp_t e;
      e.id  = id;
      e.key = key;
      exp_q.push_back(e);
   endtask

   // One clock: requester-hold rule, hash table model, result driver, scoreboard.
   task automatic tick();
      logic        hs;
      ht_command_t c;
      exp_t        e;
      hs = ht_cmd_valid & ht_cmd_ready & rst_n;
      c  = ht_cmd;
      if (rule_chk && rst_n) begin
         for (int i = 0; i < N; i++) begin
            if (pv_v[i] && !pv_r[i]) begin
               assert (req_valid[i] && (req_cmd[i] === pv_c[i])) else begin
                  errors++;
                  $error("FAIL req_hold[%0d]: observed valid=%0b cmd=0x%0h expected valid=1 cmd=0x%0h",
                         i, req_valid[i], req_cmd[i], pv_c[i]);
               end
            end
         end
      end
      pv_v = req_valid;
      pv_r = req_ready;
      pv_c = req_cmd;
      @(posedge clk);
      cyc++;
      if (hs) begin
         hq_cmd.push_back(c);
         hq_due.push_back(cyc + LAT);
      end
      #1;
      ht_result_valid = 1'b0;
      if (ht_auto && hq_cmd.size() > 0 && hq_due[0] <= cyc) begin
         ht_result.cmd   = hq_cmd.pop_front();
         void'(hq_due.pop_front());
         ht_result.hit   = 1'b1;
         ht_result.value = ~ht_result.cmd.key;
         ht_result_valid = 1'b1;
      end
      if (res_valid !== '0) begin
         n_res++;
         if (exp_q.size() == 0) begin
            chk("res_unexpected", 64'(res_valid), 64'(0));
         end else begin
            e = exp_q.pop_front();
            chk("res_owner", 64'(res_valid), 64'(1) << e.id);
            chk("res_key", 64'(res.cmd.key), 64'(e.key));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1);
   end

   initial begin
      bit got;
      int n0;
      rst_n           = 1'b0;
      req_valid       = '0;
      req_cmd         = '0;
      ht_cmd_ready    = 1'b1;
      ht_result       = '0;
      ht_result_valid = 1'b0;

      // reset state
      #2;
      chk("rst_cmd_vld",   64'(ht_cmd_valid), 64'(0));
      chk("rst_res_vld",   64'(res_valid),    64'(0));
      chk("rst_in_flight", 64'(in_flight),    64'(0));
      chk("rst_err",       64'(err),          64'(0));
      chk("rst_ready",     64'(req_ready),    64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("idle_ready", 64'(req_ready), 64'(0));

      // 1: four continuous SEARCH requesters, round robin from req 0
      ht_auto = 1'b1;
      for (int i = 0; i < N; i++) req_cmd[i] = mk(OP_SEARCH, 16'h0010 + 16'(i));
      req_valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("t1_grant", 64'(req_ready), 64'(1) << (i % 4));
         push_exp(i % 4, 16'h0010 + 16'(i % 4));
         tick();
         chk("t1_cmd_key", 64'(ht_cmd.key), 64'(16'h0010 + 16'(i % 4)));
         chk("t1_cmd_vld", 64'(ht_cmd_valid), 64'(1));
      end
      req_valid = '0;
      repeat (12) tick();
      chk("t1_drain_inflight", 64'(in_flight), 64'(0));
      chk("t1_scoreboard_empty", 64'(exp_q.size()), 64'(0));

      // 2: req 2 issues three INSERTs, results return LAT cycles later
      rule_chk = 1'b1;
      n0 = n_res;
      for (int j = 0; j < 3; j++) begin
         req_cmd[2] = mk(OP_INSERT, 16'h0200 + 16'(j));
         req_valid  = 4'b0100;
         #1;
         chk("t2_grant", 64'(req_ready), 64'(4'b0100));
         push_exp(2, 16'h0200 + 16'(j));
         tick();
      end
      req_valid = '0;
      repeat (12) tick();
      chk("t2_nres", 64'(n_res - n0), 64'(3));
      chk("t2_scoreboard_empty", 64'(exp_q.size()), 64'(0));
      rule_chk = 1'b0;

      // 3: back-pressure, then fill the tag FIFO
      ht_auto      = 1'b0;
      ht_cmd_ready = 1'b0;
      for (int i = 0; i < N; i++) req_cmd[i] = mk(OP_SEARCH, 16'h0300 + 16'(i));
      req_valid = 4'hF;
      #1;
      chk("t3_first_grant", 64'(req_ready), 64'(4'b1000));
      push_exp(3, 16'h0303);
      tick();
      chk("t3_inflight_1", 64'(in_flight), 64'(1));
      chk("t3_cmd_vld", 64'(ht_cmd_valid), 64'(1));
      repeat (3) begin
         #1;
         chk("t3_stall_ready", 64'(req_ready), 64'(0));
         chk("t3_cmd_stable", 64'(ht_cmd.key), 64'(16'h0303));
         tick();
      end
      chk("t3_inflight_held", 64'(in_flight), 64'(1));
      ht_cmd_ready = 1'b1;
      for (int k = 1; k < TD; k++) begin
         #1;
         chk("t3_fill_grant", 64'(req_ready), 64'(1) << ((k - 1) % 4));
         push_exp((k - 1) % 4, 16'h0300 + 16'((k - 1) % 4));
         tick();
      end
      #1;
      chk("t3_full_count", 64'(in_flight), 64'(16));
      chk("t3_full_ready", 64'(req_ready), 64'(0));
      tick();
      chk("t3_full_count_held", 64'(in_flight), 64'(16));

      // 5b: push and pop in the same cycle while full
      ht_result.cmd   = hq_cmd.pop_front();
      void'(hq_due.pop_front());
      ht_result.hit   = 1'b1;
      ht_result.value = '0;
      ht_result_valid = 1'b1;
      #1;
      chk("t5_pushpop_grant", 64'(req_ready), 64'(4'b1000));
      push_exp(3, 16'h0303);
      tick();
      chk("t5_pushpop_count", 64'(in_flight), 64'(16));
      req_valid = '0;
      ht_auto   = 1'b1;
      repeat (25) tick();
      chk("t3_drain_inflight", 64'(in_flight), 64'(0));
      chk("t3_scoreboard_empty", 64'(exp_q.size()), 64'(0));

      // 4: INIT waits for the pipe to drain, then blocks everything until its result
      rule_chk = 1'b1;
      for (int j = 0; j < 3; j++) begin
         req_cmd[0] = mk(OP_SEARCH, 16'h0400 + 16'(j));
         req_valid  = 4'b0001;
         #1;
         chk("t4_search_grant", 64'(req_ready), 64'(4'b0001));
         push_exp(0, 16'h0400 + 16'(j));
         tick();
      end
      n0         = n_res;
      req_cmd[0] = mk(OP_SEARCH, 16'h0410);
      req_cmd[1] = mk(OP_INIT, 16'h04F0);
      req_valid  = 4'b0011;
      #1;
      chk("t4_drain_block", 64'(req_ready), 64'(0));
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         tick();
         #1;
         if (req_ready !== '0) got = 1'b1;
      end
      chk("t4_init_grant", 64'(req_ready), 64'(4'b0010));
      chk("t4_init_after_drain", 64'(n_res - n0), 64'(3));
      chk("t4_init_inflight", 64'(in_flight), 64'(0));
      chk("t4_init_cmd_vld", 64'(ht_cmd_valid), 64'(0));
      push_exp(1, 16'h04F0);
      tick();
      chk("t4_init_issued", 64'(ht_cmd.op), 64'(OP_INIT));
      req_valid = 4'b0001;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         #1;
         if (req_ready !== '0) got = 1'b1;
         else tick();
      end
      chk("t4_req0_grant", 64'(req_ready), 64'(4'b0001));
      chk("t4_req0_after_init", 64'(n_res - n0), 64'(4));
      push_exp(0, 16'h0410);
      tick();
      req_valid = '0;
      repeat (12) tick();
      chk("t4_drain_inflight", 64'(in_flight), 64'(0));
      chk("t4_scoreboard_empty", 64'(exp_q.size()), 64'(0));
      rule_chk = 1'b0;

      // 5: result with an empty tag FIFO
      ht_auto = 1'b0;
      chk("t5_err_pre", 64'(err), 64'(0));
      ht_result.cmd   = mk(OP_SEARCH, 16'h05AA);
      ht_result.hit   = 1'b0;
      ht_result.value = '0;
      ht_result_valid = 1'b1;
      tick();
      chk("t5_err_set", 64'(err), 64'(1));
      chk("t5_no_res_vld", 64'(res_valid), 64'(0));
      tick();
      chk("t5_err_held", 64'(err), 64'(1));
      chk("t5_no_res_vld_2", 64'(res_valid), 64'(0));

      // 6: asynchronous reset in the middle of a burst
      for (int i = 0; i < N; i++) req_cmd[i] = mk(OP_SEARCH, 16'h0600 + 16'(i));
      req_valid    = 4'hF;
      ht_cmd_ready = 1'b1;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_cmd_vld", 64'(ht_cmd_valid), 64'(0));
      chk("t6_cmd",     64'(ht_cmd),       64'(0));
      chk("t6_ready",   64'(req_ready),    64'(0));
      chk("t6_inflight",64'(in_flight),    64'(0));
      chk("t6_err",     64'(err),          64'(0));
      chk("t6_res_vld", 64'(res_valid),    64'(0));
      hq_cmd.delete();
      hq_due.delete();
      tick();
      rst_n = 1'b1;
      #1;
      chk("t6_first_grant", 64'(req_ready), 64'(4'b0001));
      tick();
      chk("t6_first_cmd", 64'(ht_cmd.key), 64'(16'h0600));
      req_valid = '0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
